// File: rtl/tmul_fma_seq_if.sv
// Handshake/bus bundle for the TMUL FMA sequencer.
//   cmd_*  : dot-product command (length, initial accumulator), valid/ready
//   op_*   : operand-pair stream, valid/ready
//   fma_*  : registered operands to the external FMA pipeline and its result
//   res_*  : final accumulator return, valid/ready
// Modports: slave = sequencer side, master = command/operand source and FMA side.
interface tmul_fma_seq_if #(
  parameter int unsigned LEN_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic [63:0]      cmd_init;

  logic             op_valid;
  logic             op_ready;
  logic [31:0]      op_a;
  logic [31:0]      op_b;

  logic [31:0]      fma_a;
  logic [31:0]      fma_b;
  logic [63:0]      fma_c;
  logic [63:0]      fma_out;

  logic             res_valid;
  logic             res_ready;
  logic [63:0]      res_data;

  modport slave (
    input  cmd_valid, cmd_len, cmd_init,
    output cmd_ready,
    input  op_valid, op_a, op_b,
    output op_ready,
    output fma_a, fma_b, fma_c,
    input  fma_out,
    output res_valid, res_data,
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_len, cmd_init,
    input  cmd_ready,
    output op_valid, op_a, op_b,
    input  op_ready,
    input  fma_a, fma_b, fma_c,
    output fma_out,
    input  res_valid, res_data,
    output res_ready
  );
endinterface

// File: rtl/tmul_fma_seq.sv
// Sequencer for the pipelined 32x32->64 FMA (out = a*b + c) in the TMUL
// datapath. Accepts a dot-product command, feeds N operand pairs to the FMA
// one at a time with the running accumulator as c, captures each result back
// into the accumulator, and returns the final 64-bit sum.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset (shared with the FMA pipeline)
//   abort  : synchronous abort of the current command (no result produced)
//   busy   : high whenever the sequencer is not idle
//   bus    : cmd/op/fma/res bundle (tmul_fma_seq_if.slave)
module tmul_fma_seq #(
  parameter int unsigned FMA_LAT = 2,
  parameter int unsigned LEN_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          abort,
  output logic          busy,
  tmul_fma_seq_if.slave bus
);

  localparam int unsigned WCW = (FMA_LAT < 1) ? 1 : $clog2(FMA_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t           state;
  logic [63:0]      acc;
  logic [LEN_W-1:0] rem;
  logic [WCW-1:0]   wcnt;
  logic [31:0]      fa;
  logic [31:0]      fb;
  logic [63:0]      fc;

  // Only one FMA operation is in flight: the accumulator is read at issue
  // and not re-read until its update has been captured, so there is no
  // read-after-write hazard to forward around.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      wcnt  <= '0;
      fa    <= '0;
      fb    <= '0;
      fc    <= '0;
    end else if (abort && (state != IDLE)) begin
      // Abort outranks any handshake or capture in the same cycle; the
      // accumulator and FMA operands are left as they are.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            acc   <= bus.cmd_init;
            rem   <= bus.cmd_len;
            state <= (bus.cmd_len == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (bus.op_valid) begin
            fa    <= bus.op_a;
            fb    <= bus.op_b;
            fc    <= acc;
            wcnt  <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          // Operands became stable at the issue edge; the FMA result is
          // valid FMA_LAT edges later and is captured on the following edge.
          if (wcnt == WCW'(FMA_LAT)) begin
            acc   <= bus.fma_out;
            rem   <= rem - LEN_W'(1);
            state <= (rem == LEN_W'(1)) ? DONE : ISSUE;
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.op_ready  = (state == ISSUE);
  assign bus.res_valid = (state == DONE);
  assign bus.res_data  = acc;
  assign bus.fma_a     = fa;
  assign bus.fma_b     = fb;
  assign bus.fma_c     = fc;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_tmul_fma_seq.sv
// Directed self-checking bench for tmul_fma_seq. Models the external
// 2-stage FMA pipeline (out = a*b + c mod 2^64, reset with rst) and drives
// command, operand and result handshakes with hand-computed expectations.
module tb_tmul_fma_seq;

  logic clk = 1'b0;
  logic rst;
  logic abort;
  logic busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] pa [4];
  logic [31:0] pb [4];

  tmul_fma_seq_if #(.LEN_W(16)) bus ();

  tmul_fma_seq #(
    .FMA_LAT(2),
    .LEN_W  (16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .abort(abort),
    .busy (busy),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // External FMA: two register stages, unsigned product, carry-out dropped.
  logic [63:0] s1, s2;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ({32'd0, bus.fma_a} * {32'd0, bus.fma_b}) + bus.fma_c;
      s2 <= s1;
    end
  end
  assign bus.fma_out = s2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one command to completion. gap: cycles op_valid is held low while
  // op_ready is high between pairs. rhold: cycles res_ready is held low
  // after res_valid rises. exp_lat: edges after the command edge at which
  // res_valid is first seen.
  task automatic run_cmd(input string tag, input int len, input logic [63:0] init,
                         input int gap, input int rhold,
                         input logic [63:0] exp, input int exp_lat);
    int idx = 0, gcnt = 0, since = 99, cyc = 0, hold = 0;
    bit done = 0, seen = 0, acc_now, resh, rdy_now;
    chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = len[15:0];
    bus.cmd_init  = init;
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    while (!done && cyc < 300) begin
      if (bus.res_valid && !seen) begin
        seen = 1;
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_res"}, bus.res_data, exp);
      end else if (bus.res_valid) begin
        chk({tag, "_res_stable"}, bus.res_data, exp);
      end
      if (since < 3) chk({tag, "_op_ready_wait"}, 64'(bus.op_ready), 64'd0);
      bus.op_valid  = (idx < len) && (gcnt == 0);
      bus.op_a      = (idx < 4) ? pa[idx] : '0;
      bus.op_b      = (idx < 4) ? pb[idx] : '0;
      bus.res_ready = bus.res_valid && (hold >= rhold);
      acc_now = bus.op_valid && bus.op_ready;
      resh    = bus.res_valid && bus.res_ready;
      rdy_now = bus.op_ready;
      if (bus.res_valid && !bus.res_ready) hold++;
      tick();
      cyc++;
      if (acc_now) begin
        idx++;
        since = 0;
        gcnt  = gap;
      end else begin
        if (since < 99) since++;
        if (rdy_now && gcnt > 0) gcnt--;
      end
      if (resh) begin
        done = 1;
        chk({tag, "_res_valid_drop"}, 64'(bus.res_valid), 64'd0);
        chk({tag, "_idle_after"}, 64'(bus.cmd_ready), 64'd1);
      end
    end
    chk({tag, "_completed"}, 64'(done), 64'd1);
    chk({tag, "_pairs_used"}, 64'(idx), 64'(len));
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    abort = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_init  = '0;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b0;
    #12;
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_op_ready", 64'(bus.op_ready), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_data", bus.res_data, 64'd0);
    chk("rst_fma_c", bus.fma_c, 64'd0);
    rst = 1'b1;
    tick();

    // Basic: 0 + 2*3 + 4*5 + 6*7 = 68
    pa[0] = 32'd2; pb[0] = 32'd3;
    pa[1] = 32'd4; pb[1] = 32'd5;
    pa[2] = 32'd6; pb[2] = 32'd7;
    run_cmd("basic", 3, 64'd0, 0, 0, 64'd68, 12);
    chk("basic_fma_a", 64'(bus.fma_a), 64'd6);
    chk("basic_fma_b", 64'(bus.fma_b), 64'd7);
    chk("basic_fma_c", bus.fma_c, 64'd26);
    tick();

    // Zero length: result is the initial value, FMA operands untouched.
    run_cmd("zero_len", 0, 64'h1234, 0, 0, 64'h1234, 0);
    chk("zero_fma_a", 64'(bus.fma_a), 64'd6);
    chk("zero_fma_b", 64'(bus.fma_b), 64'd7);
    chk("zero_fma_c", bus.fma_c, 64'd26);

    // Single element: 100 + 10*10
    pa[0] = 32'd10; pb[0] = 32'd10;
    run_cmd("len1", 1, 64'd100, 0, 0, 64'd200, 4);

    // Wrap-around: (2^32-1)^2 + (2^64-1) mod 2^64
    pa[0] = 32'hFFFF_FFFF; pb[0] = 32'hFFFF_FFFF;
    run_cmd("wrap", 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'hFFFF_FFFE_0000_0000, 4);

    // Backpressure: 5 + 1*1 + 3*3 with gaps on both streams
    pa[0] = 32'd1; pb[0] = 32'd1;
    pa[1] = 32'd3; pb[1] = 32'd3;
    run_cmd("bp", 2, 64'd5, 3, 5, 64'd15, 11);

    // Abort during the WAIT of element 2 of 3; acc holds 2*3 = 6.
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 16'd3;
    bus.cmd_init  = 64'd0;
    bus.op_valid  = 1'b1;
    bus.op_a      = 32'd2;
    bus.op_b      = 32'd3;
    tick();
    bus.cmd_valid = 1'b0;
    repeat (6) tick();
    chk("abort_in_wait", 64'(bus.op_ready), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    bus.op_valid = 1'b0;
    chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_res", 64'(bus.res_valid), 64'd0);
      chk("abort_acc_held", bus.res_data, 64'd6);
      tick();
    end
    pa[0] = 32'd7; pb[0] = 32'd8;
    run_cmd("post_abort", 1, 64'd0, 0, 0, 64'd56, 4);

    // Async reset mid-ISSUE after one element: 5 + 3*4 = 17 accumulated.
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 16'd2;
    bus.cmd_init  = 64'd5;
    bus.op_valid  = 1'b1;
    bus.op_a      = 32'd3;
    bus.op_b      = 32'd4;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.op_valid = 1'b0;
    repeat (3) tick();
    chk("pre_rst_issue", 64'(bus.op_ready), 64'd1);
    chk("pre_rst_fma_a", 64'(bus.fma_a), 64'd3);
    chk("pre_rst_fma_c", bus.fma_c, 64'd5);
    chk("pre_rst_acc", bus.res_data, 64'd17);
    #3 rst = 1'b0;
    #1;
    chk("arst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("arst_op_ready", 64'(bus.op_ready), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_res_data", bus.res_data, 64'd0);
    chk("arst_fma_a", 64'(bus.fma_a), 64'd0);
    chk("arst_fma_b", 64'(bus.fma_b), 64'd0);
    chk("arst_fma_c", bus.fma_c, 64'd0);
    #2 rst = 1'b1;
    tick();
    pa[0] = 32'd9; pb[0] = 32'd9;
    run_cmd("post_rst", 1, 64'd0, 0, 0, 64'd81, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
